// File: rtl/param_stack_unit_pkg.sv
// Shared opcode and FSM state encodings for the stack unit.
package stack_unit_pkg;

    typedef enum logic [2:0] {
        OP_PUSH  = 3'd0,
        OP_POP   = 3'd1,
        OP_SUM   = 3'd2,
        OP_SUB   = 3'd3,
        OP_AVG   = 3'd4,
        OP_PEEK  = 3'd5,
        OP_DUP   = 3'd6,
        OP_CLEAR = 3'd7
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXEC,
        ST_ACCUM,
        ST_DIV,
        ST_DONE
    } state_t;

endpackage

// File: rtl/param_stack_unit_if.sv
// Request/response bundle between a requester (master) and the stack unit (slave).
interface param_stack_unit_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024
) ();
    localparam int NW = $clog2(DEPTH) + 1;

    logic             rdy_in;
    logic [2:0]       op;
    logic [WIDTH-1:0] datain;
    logic [NW-1:0]    n;
    logic [WIDTH-1:0] dataout;
    logic             esito;
    logic             ack;
    logic [NW-1:0]    count;
    logic             full;
    logic             empty;

    modport master (
        output rdy_in, op, datain, n,
        input  dataout, esito, ack, count, full, empty
    );

    modport slave (
        input  rdy_in, op, datain, n,
        output dataout, esito, ack, count, full, empty
    );
endinterface

// File: rtl/param_stack_unit_seq_divider.sv
// Unsigned restoring divider: one quotient bit per cycle, start/done handshake.
module seq_divider #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic         done
);
    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  rem;
    logic [W-1:0]  quo;
    logic [CW-1:0] cnt;
    logic          busy;
    logic [W:0]    trial;
    logic [W:0]    diff;

    // Trial subtraction of the shifted partial remainder; diff[W] is the borrow.
    always_comb begin
        trial = {rem, quo[W-1]};
        diff  = trial - {1'b0, divisor};
    end

    // Load on start, then shift/subtract W times and pulse done.
    always_ff @(posedge clock) begin
        if (reset) begin
            rem  <= '0;
            quo  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                rem  <= '0;
                quo  <= dividend;
                cnt  <= CW'(W);
                busy <= 1'b1;
            end else if (busy) begin
                if (!diff[W]) begin
                    rem <= diff[W-1:0];
                    quo <= {quo[W-2:0], 1'b1};
                end else begin
                    rem <= trial[W-1:0];
                    quo <= {quo[W-2:0], 1'b0};
                end
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign quotient = quo;
endmodule

// File: rtl/param_stack_unit.sv
// Toggle-handshake stack unit: push/pop/arithmetic on a synchronous-read stack.
module param_stack_unit
    import stack_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024
) (
    input  logic               clock,
    input  logic               reset,
    param_stack_unit_if.slave  bus
);
    localparam int NW   = $clog2(DEPTH) + 1;
    localparam int AW   = $clog2(DEPTH);
    localparam int ACCW = WIDTH + $clog2(DEPTH);
    localparam logic [NW-1:0] DEPTH_C = NW'(DEPTH);

    state_t           state;
    op_t              op_q;
    logic             rdy_q, ack_q, esito_q, full_q, empty_q, avg_ok;
    logic [WIDTH-1:0] din_q, top_q, rd_data, dataout_q, avg_q;
    logic [NW-1:0]    n_q, count_q, rcv;
    logic [AW-1:0]    iss, rd_addr, top_addr;
    logic [ACCW-1:0]  acc, dividend, divisor, quo;
    logic             div_start, div_done, quo_unused;
    logic [WIDTH-1:0] mem [DEPTH];

    logic             res_ok, do_write;
    logic [WIDTH-1:0] res_data, wr_data;
    logic [NW-1:0]    res_count;

    // Read address: top during IDLE/DONE, second in EXEC, walking down in ACCUM.
    always_comb begin
        top_addr = count_q[AW-1:0] - AW'(1);
        case (state)
            ST_EXEC:  rd_addr = top_addr - AW'(1);
            ST_ACCUM: rd_addr = top_addr - iss;
            default:  rd_addr = top_addr;
        endcase
    end

    // Stack storage with registered read; writes only on completion.
    always_ff @(posedge clock) begin
        if (state == ST_DONE && do_write && !reset)
            mem[count_q[AW-1:0]] <= wr_data;
        rd_data <= mem[rd_addr];
    end

    // Outcome of the captured op, applied on the DONE edge.
    always_comb begin
        res_ok    = 1'b0;
        res_data  = dataout_q;
        res_count = count_q;
        do_write  = 1'b0;
        wr_data   = din_q;
        case (op_q)
            OP_PUSH: if (!full_q) begin
                res_ok = 1'b1; res_data = din_q; res_count = count_q + NW'(1); do_write = 1'b1;
            end
            OP_POP: if (!empty_q) begin
                res_ok = 1'b1; res_data = top_q; res_count = count_q - NW'(1);
            end
            OP_SUM: if (count_q >= NW'(2)) begin
                res_ok = 1'b1; res_data = top_q + rd_data;
            end
            OP_SUB: if (count_q >= NW'(2)) begin
                res_ok = 1'b1; res_data = top_q - rd_data;
            end
            OP_AVG: if (avg_ok) begin
                res_ok = 1'b1; res_data = avg_q;
            end
            OP_PEEK: if (!empty_q) begin
                res_ok = 1'b1; res_data = top_q;
            end
            OP_DUP: if (!empty_q && !full_q) begin
                res_ok = 1'b1; res_data = top_q; res_count = count_q + NW'(1);
                do_write = 1'b1; wr_data = top_q;
            end
            OP_CLEAR: begin
                res_ok = 1'b1; res_data = '0; res_count = '0;
            end
            default: ;
        endcase
    end

    // The divider sees the magnitude; the sign is restored when the quotient returns.
    assign dividend   = acc[ACCW-1] ? -acc : acc;
    assign divisor    = ACCW'(n_q);
    assign quo_unused = ^quo[ACCW-1:WIDTH];

    seq_divider #(.W(ACCW)) u_div (
        .clock    (clock),
        .reset    (reset),
        .start    (div_start),
        .dividend (dividend),
        .divisor  (divisor),
        .quotient (quo),
        .done     (div_done)
    );

    // Control FSM: request detection, operand fetch, AVG accumulate/divide, completion.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            dataout_q <= '0;
            esito_q   <= 1'b0;
            rdy_q     <= bus.rdy_in;
            ack_q     <= bus.rdy_in;
            div_start <= 1'b0;
            avg_ok    <= 1'b0;
        end else begin
            div_start <= 1'b0;
            case (state)
                ST_IDLE: if (bus.rdy_in != rdy_q) begin
                    rdy_q <= bus.rdy_in;
                    op_q  <= op_t'(bus.op);
                    din_q <= bus.datain;
                    n_q   <= bus.n;
                    acc   <= '0;
                    iss   <= AW'(1);
                    rcv   <= '0;
                    if (op_t'(bus.op) == OP_AVG && bus.n != '0 && bus.n <= count_q) begin
                        avg_ok <= 1'b1;
                        state  <= ST_ACCUM;
                    end else begin
                        avg_ok <= 1'b0;
                        state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    top_q <= rd_data;
                    state <= ST_DONE;
                end
                // rd_data lags the address by one cycle, so the top word is already
                // waiting on entry and iss runs one element ahead of rcv.
                ST_ACCUM: begin
                    acc <= acc + {{(ACCW-WIDTH){rd_data[WIDTH-1]}}, rd_data};
                    iss <= iss + AW'(1);
                    rcv <= rcv + NW'(1);
                    if (rcv == n_q - NW'(1)) begin
                        div_start <= 1'b1;
                        state     <= ST_DIV;
                    end
                end
                ST_DIV: if (div_done) begin
                    avg_q <= acc[ACCW-1] ? -quo[WIDTH-1:0] : quo[WIDTH-1:0];
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    dataout_q <= res_data;
                    esito_q   <= res_ok;
                    count_q   <= res_count;
                    full_q    <= (res_count == DEPTH_C);
                    empty_q   <= (res_count == '0);
                    ack_q     <= rdy_q;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.dataout = dataout_q;
    assign bus.esito   = esito_q;
    assign bus.ack     = ack_q;
    assign bus.count   = count_q;
    assign bus.full    = full_q;
    assign bus.empty   = empty_q;
endmodule

// File: tb/tb_param_stack_unit.sv
// Directed bench for param_stack_unit: vector table plus reset/full-stack sequences.
module tb_param_stack_unit;
    import stack_unit_pkg::*;

    localparam int WIDTH = 32;
    localparam int DEPTH = 1024;
    localparam int NW    = 11;
    localparam int ACCW  = 42;
    localparam int NVEC  = 34;

    typedef struct {
        logic [2:0] op;
        int         data;
        int         nn;
        int         exp_data;
        bit         exp_ok;
        int         exp_count;
    } vec_t;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs [NVEC];

    always #5 clock = ~clock;

    param_stack_unit_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    param_stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] o, input int d, input int nn);
        @(negedge clock);
        bus.op     = o;
        bus.datain = d;
        bus.n      = NW'(nn);
        bus.rdy_in = ~bus.rdy_in;
    endtask

    task automatic req(input logic [2:0] o, input int d, input int nn, output int lat);
        issue(o, d, nn);
        lat = 0;
        while (bus.ack != bus.rdy_in && lat < 2000) begin
            @(negedge clock);
            lat++;
        end
        if (bus.ack != bus.rdy_in) chk("ack_timeout", bus.ack, bus.rdy_in);
    endtask

    task automatic check_out(input string tag, input int exp_data, input bit exp_ok,
                             input int exp_count);
        chk({tag, "_data"},  longint'($signed(bus.dataout)), exp_data);
        chk({tag, "_esito"}, bus.esito, exp_ok);
        chk({tag, "_count"}, bus.count, exp_count);
        chk({tag, "_full"},  bus.full,  exp_count == DEPTH);
        chk({tag, "_empty"}, bus.empty, exp_count == 0);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ack"},   bus.ack, bus.rdy_in);
        check_out(tag, 0, 1'b0, 0);
    endtask

    initial begin
        int lat;

        vecs[0]  = '{OP_PUSH, 1023, 0, 1023, 1'b1, 1};
        vecs[1]  = '{OP_POP,  0,    0, 1023, 1'b1, 0};
        vecs[2]  = '{OP_POP,  0,    0, 1023, 1'b0, 0};
        vecs[3]  = '{OP_PUSH, 500,  0, 500,  1'b1, 1};
        vecs[4]  = '{OP_PUSH, 750,  0, 750,  1'b1, 2};
        vecs[5]  = '{OP_SUM,  0,    0, 1250, 1'b1, 2};
        vecs[6]  = '{OP_SUB,  0,    0, 250,  1'b1, 2};
        vecs[7]  = '{OP_PUSH, 1200, 0, 1200, 1'b1, 3};
        vecs[8]  = '{OP_PUSH, 300,  0, 300,  1'b1, 4};
        vecs[9]  = '{OP_AVG,  0,    4, 687,  1'b1, 4};
        vecs[10] = '{OP_AVG,  0,    5, 687,  1'b0, 4};
        vecs[11] = '{OP_AVG,  0,    0, 687,  1'b0, 4};
        vecs[12] = '{OP_CLEAR, 0,   0, 0,    1'b1, 0};
        vecs[13] = '{OP_PUSH, -7,   0, -7,   1'b1, 1};
        vecs[14] = '{OP_SUM,  0,    0, -7,   1'b0, 1};
        vecs[15] = '{OP_PUSH, 2,    0, 2,    1'b1, 2};
        vecs[16] = '{OP_AVG,  0,    2, -2,   1'b1, 2};
        vecs[17] = '{OP_SUB,  0,    0, 9,    1'b1, 2};
        vecs[18] = '{OP_CLEAR, 0,   0, 0,    1'b1, 0};
        vecs[19] = '{OP_PEEK, 0,    0, 0,    1'b0, 0};
        vecs[20] = '{OP_DUP,  0,    0, 0,    1'b0, 0};
        vecs[21] = '{OP_PUSH, 9,    0, 9,    1'b1, 1};
        vecs[22] = '{OP_DUP,  0,    0, 9,    1'b1, 2};
        vecs[23] = '{OP_PEEK, 0,    0, 9,    1'b1, 2};
        vecs[24] = '{OP_AVG,  0,    2, 9,    1'b1, 2};
        vecs[25] = '{OP_POP,  0,    0, 9,    1'b1, 1};
        vecs[26] = '{OP_CLEAR, 0,   0, 0,    1'b1, 0};
        vecs[27] = '{OP_PUSH, -10,  0, -10,  1'b1, 1};
        vecs[28] = '{OP_PUSH, 3,    0, 3,    1'b1, 2};
        vecs[29] = '{OP_PUSH, 0,    0, 0,    1'b1, 3};
        vecs[30] = '{OP_AVG,  0,    3, -2,   1'b1, 3};
        vecs[31] = '{OP_AVG,  0,    1, 0,    1'b1, 3};
        vecs[32] = '{OP_SUB,  0,    0, -3,   1'b1, 3};
        vecs[33] = '{OP_CLEAR, 0,   0, 0,    1'b1, 0};

        // Reset: ack must track rdy_in while held, and no request appears on release.
        reset      = 1'b1;
        bus.rdy_in = 1'b0;
        bus.op     = '0;
        bus.datain = '0;
        bus.n      = '0;
        repeat (2) @(negedge clock);
        bus.rdy_in = 1'b1;
        @(negedge clock);
        check_reset("reset");
        reset = 1'b0;
        repeat (4) @(negedge clock);
        check_reset("post_reset");

        // Directed vector table.
        for (int i = 0; i < NVEC; i++) begin
            req(vecs[i].op, vecs[i].data, vecs[i].nn, lat);
            check_out($sformatf("v%0d", i), vecs[i].exp_data, vecs[i].exp_ok, vecs[i].exp_count);
            if (vecs[i].op == OP_AVG && vecs[i].exp_ok)
                chk($sformatf("v%0d_avg_lat_ok", i), lat <= vecs[i].nn + ACCW + 5, 1);
            else
                chk($sformatf("v%0d_lat", i), lat, 3);
        end

        // Fill to capacity, overflow, deep averages, then drain.
        for (int i = 0; i < DEPTH; i++) begin
            req(OP_PUSH, i, 0, lat);
            chk($sformatf("fill%0d_esito", i), bus.esito, 1);
            chk($sformatf("fill%0d_count", i), bus.count, i + 1);
        end
        check_out("filled", 1023, 1'b1, 1024);
        req(OP_PUSH, 77, 0, lat);
        check_out("overflow", 1023, 1'b0, 1024);
        req(OP_DUP, 0, 0, lat);
        check_out("dup_full", 1023, 1'b0, 1024);
        req(OP_AVG, 0, 1024, lat);
        check_out("avg1024", 511, 1'b1, 1024);
        chk("avg1024_lat_ok", lat <= 1024 + ACCW + 5, 1);
        req(OP_AVG, 0, 1000, lat);
        check_out("avg1000", 523, 1'b1, 1024);
        req(OP_AVG, 0, 1025, lat);
        check_out("avg1025", 523, 1'b0, 1024);
        for (int i = DEPTH - 1; i >= 0; i--) begin
            req(OP_POP, 0, 0, lat);
            chk($sformatf("drain%0d_data", i), longint'($signed(bus.dataout)), i);
            chk($sformatf("drain%0d_esito", i), bus.esito, 1);
        end
        check_out("drained", 0, 1'b1, 0);

        // Reset while AVG n=1000 is accumulating.
        for (int i = 0; i < 1000; i++) req(OP_PUSH, i + 1, 0, lat);
        chk("pre_accum_count", bus.count, 1000);
        issue(OP_AVG, 0, 1000);
        repeat (500) @(negedge clock);
        chk("accum_pending", bus.ack, !bus.rdy_in);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        check_reset("accum_abort");
        repeat (1100) @(negedge clock);
        check_reset("accum_abort_late");
        req(OP_PUSH, 5, 0, lat);
        check_out("after_accum_abort", 5, 1'b1, 1);
        chk("after_accum_abort_lat", lat, 3);

        // Reset while the divider is running.
        req(OP_PUSH, 6, 0, lat);
        req(OP_PUSH, 7, 0, lat);
        req(OP_PUSH, 8, 0, lat);
        issue(OP_AVG, 0, 4);
        repeat (15) @(negedge clock);
        chk("div_pending", bus.ack, !bus.rdy_in);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        check_reset("div_abort");
        repeat (60) @(negedge clock);
        check_reset("div_abort_late");
        req(OP_PUSH, 11, 0, lat);
        check_out("after_div_abort", 11, 1'b1, 1);
        req(OP_AVG, 0, 1, lat);
        check_out("after_div_abort_avg", 11, 1'b1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/param_stack_unit.md
PARAM_STACK_UNIT -- requirements
Module: param_stack_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 1024: stack capacity in words (power of two, >=4).
REQ-003 SHALL define derived NW = clog2(DEPTH)+1 and ACCW = WIDTH+clog2(DEPTH).
REQ-004 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port rdy_in  input  1  request line; each level transition means a new request.
REQ-007 SHALL have port op  input  3  opcode: 0 PUSH, 1 POP, 2 SUM, 3 SUB, 4 AVG, 5 PEEK, 6 DUP, 7 CLEAR.
REQ-008 SHALL have port datain  input  WIDTH  signed PUSH operand.
REQ-009 SHALL have port n  input  NW  AVG element count.
REQ-010 SHALL have port dataout  output  WIDTH  signed result of the last successful op.
REQ-011 SHALL have port esito  output  1  1 = last op succeeded, 0 = rejected.
REQ-012 SHALL have port ack  output  1  toggles once per completed request.
REQ-013 SHALL have ports count (output, NW), full (output, 1) and empty (output, 1): occupancy flags.

Function
REQ-014 Request detected when in IDLE and rdy_in != registered copy rdy_q; op, datain and n captured at that edge; rdy_q updated.
REQ-015 rdy_in sampled only in IDLE; requester must not toggle again until ack == rdy_in.
REQ-016 Completion: dataout and esito updated and ack toggled on the same edge; ack then equals rdy_q.
REQ-017 Latency: all ops except AVG toggle ack exactly 2 cycles after the detection edge.
REQ-018 Latency: AVG toggles ack no later than n+ACCW+4 cycles after detection.
REQ-019 FSM states IDLE -> EXEC -> DONE -> IDLE; AVG path IDLE -> ACCUM (one element/cycle) -> DIV -> DONE.
REQ-020 PUSH: if not full, write datain and count+1, dataout=datain, esito=1.
REQ-021 POP: if not empty, dataout=top and count-1, esito=1.
REQ-022 PEEK: if not empty, dataout=top, esito=1; stack unchanged.
REQ-023 DUP: requires 1 <= count < DEPTH; pushes a copy of top, dataout=top.
REQ-024 SUM: requires count >= 2; dataout=top+second, wrapping modulo 2^WIDTH; non-destructive.
REQ-025 SUB: requires count >= 2; dataout=top-second, wrapping modulo 2^WIDTH; non-destructive.
REQ-026 AVG: requires 1 <= n <= count; sums top n words in an ACCW-bit signed accumulator (no overflow) and divides by n.
REQ-027 AVG quotient truncates toward zero; operation is non-destructive.
REQ-028 CLEAR: count=0, dataout=0, esito=1; always succeeds.
REQ-029 Rejected op (full/empty/count/n violation, n=0): stack, count and dataout unchanged, esito=0; ack still toggles.
REQ-030 full = (count==DEPTH); empty = (count==0); both registered, consistent with count every cycle.

Reset
REQ-031 While reset=1: count=0, dataout=0, esito=0, FSM=IDLE, rdy_q<=rdy_in and ack<=rdy_in (no spurious request, unit appears idle).
REQ-032 Reset asserted mid-operation (including ACCUM/DIV) aborts it with no ack toggle and no stack modification beyond reset values.
REQ-033 Storage contents need not be reset.

Structure
REQ-034 Opcode constants and FSM state encodings SHALL live in shared package stack_unit_pkg.
REQ-035 Storage SHALL be a DEPTH x WIDTH array with synchronous read.
REQ-036 Division SHALL be a sub-module seq_divider: unsigned ACCW-bit restoring divider, start/done handshake, one quotient bit per cycle; sign fixed by the parent.

Verification (WIDTH=32, DEPTH=1024)
REQ-037 PUSH 1023, POP -> dataout=1023, esito=1, empty=1; second POP -> esito=0, dataout stays 1023.
REQ-038 PUSH 500, PUSH 750, SUM -> 1250; SUB -> 250; count remains 2 throughout.
REQ-039 Then PUSH 1200, PUSH 300, AVG n=4 -> 687; AVG n=5 -> esito=0; CLEAR, PUSH -7, PUSH 2, AVG n=2 -> -2.
REQ-040 1024 alternating-toggle PUSHes of i -> all esito=1, full=1; 1025th PUSH -> esito=0, count=1024; 1024 POPs return 1023..0.
REQ-041 PUSH 9, DUP -> count=2, dataout=9; PEEK -> 9; CLEAR -> count=0, empty=1.
REQ-042 Reset pulse during AVG n=1000 -> no ack toggle, ack==rdy_in, count=0 after release; next request serviced normally.
